cbm_step_sequencer: RTL

Sequences the CBM reservoir time-step loop around the differential multiply-accumulate datapath. Each step it:
- takes one external input/output state vector;
- issues it, together with the current hidden CBM state, to the accumulator's two state inputs;
- waits for the summed accumulation and thresholds it into the next hidden state;
- emits that state to the readout.

It sits between the host/stimulus stream and the accumulator, and owns the hidden-state register and the step counter.

---
 rtl/cbm_step_sequencer.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/cbm_step_sequencer.sv
// rtl/cbm_step_sequencer.sv - CBM reservoir time-step sequencer around the accumulator datapath
//
// Purpose: for each time step, accept one external in/out state vector, issue it with the
// current hidden state to the accumulator, threshold the returned per-neuron sums into the
// next hidden state, and emit that state to the readout. Owns hidden register and step count.
//
// Optional feature macro: CBM_SEQ_STATE_KEEP_EN
//   defined   - hidden register survives across runs (only iRST clears it)
//   undefined - hidden register is also cleared on every accepted iStart
//
// Ports:
//   iCLK, iRST                  clock, synchronous active-high reset
//   iStart, iNumStep            run start (sampled in IDLE) and step count
//   oBusy, oDone                run in progress, one-cycle end-of-run pulse
//   *_AS_EnInoutState           external state stream in (valid/ready/data, NI+NO bits)
//   *_BM_EnInoutState           input state out to accumulator
//   *_BM_CbmState               hidden state out to accumulator
//   *_AS_CbmAccum               per-neuron accumulations in (NH slices of CW bits)
//   *_BM_State                  new hidden state out to readout
module cbm_step_sequencer #(
    parameter  int NI = 1,
    parameter  int NO = 1,
    parameter  int NH = 8,
    parameter  int WS = 8,
    localparam int CW = $clog2(NI + NO + NH) + WS
) (
    input  logic                 iCLK,
    input  logic                 iRST,
    input  logic                 iStart,
    input  logic [15:0]          iNumStep,
    output logic                 oBusy,
    output logic                 oDone,
    input  logic                 iValid_AS_EnInoutState,
    output logic                 oReady_AS_EnInoutState,
    input  logic [NI+NO-1:0]     iData_AS_EnInoutState,
    output logic                 oValid_BM_EnInoutState,
    input  logic                 iReady_BM_EnInoutState,
    output logic [NI+NO-1:0]     oData_BM_EnInoutState,
    output logic                 oValid_BM_CbmState,
    input  logic                 iReady_BM_CbmState,
    output logic [NH-1:0]        oData_BM_CbmState,
    input  logic                 iValid_AS_CbmAccum,
    output logic                 oReady_AS_CbmAccum,
    input  logic [NH*CW-1:0]     iData_AS_CbmAccum,
    output logic                 oValid_BM_State,
    input  logic                 iReady_BM_State,
    output logic [NH-1:0]        oData_BM_State
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_WAIT,
        S_EMIT,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        num_step_q, num_step_d;
    logic [15:0]        step_cnt_q, step_cnt_d;
    logic [NI+NO-1:0]   in_q, in_d;
    logic [NH-1:0]      hidden_q, hidden_d;
    logic               sent_en_q, sent_en_d;
    logic               sent_cbm_q, sent_cbm_d;

    logic in_xfer, en_xfer, cbm_xfer, acc_xfer, st_xfer;
    logic en_done, cbm_done;

    // Only the sign bit of each accumulation slice is consumed.
    logic unused_acc_bits;
    assign unused_acc_bits = ^iData_AS_CbmAccum;

    // Every output decodes from registered state only; no ready/valid feed-through.
    assign oBusy                  = (state_q != S_IDLE);
    assign oDone                  = (state_q == S_DONE);
    assign oReady_AS_EnInoutState = (state_q == S_LOAD);
    assign oValid_BM_EnInoutState = (state_q == S_ISSUE) && !sent_en_q;
    assign oData_BM_EnInoutState  = in_q;
    assign oValid_BM_CbmState     = (state_q == S_ISSUE) && !sent_cbm_q;
    assign oData_BM_CbmState      = hidden_q;
    assign oReady_AS_CbmAccum     = (state_q == S_WAIT);
    assign oValid_BM_State        = (state_q == S_EMIT);
    assign oData_BM_State         = hidden_q;

    assign in_xfer  = iValid_AS_EnInoutState && oReady_AS_EnInoutState;
    assign en_xfer  = oValid_BM_EnInoutState && iReady_BM_EnInoutState;
    assign cbm_xfer = oValid_BM_CbmState && iReady_BM_CbmState;
    assign acc_xfer = iValid_AS_CbmAccum && oReady_AS_CbmAccum;
    assign st_xfer  = oValid_BM_State && iReady_BM_State;

    // A port counts as done if it already transferred or transfers this cycle.
    assign en_done  = sent_en_q || en_xfer;
    assign cbm_done = sent_cbm_q || cbm_xfer;

    always_comb begin
        state_d    = state_q;
        num_step_d = num_step_q;
        step_cnt_d = step_cnt_q;
        in_d       = in_q;
        hidden_d   = hidden_q;
        sent_en_d  = sent_en_q;
        sent_cbm_d = sent_cbm_q;

        case (state_q)
            S_IDLE: begin
                if (iStart) begin
`ifndef CBM_SEQ_STATE_KEEP_EN
                    hidden_d = '0;
`endif
                    if (iNumStep != 16'd0) begin
                        num_step_d = iNumStep;
                        step_cnt_d = 16'd0;
                        state_d    = S_LOAD;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_LOAD: begin
                if (in_xfer) begin
                    in_d    = iData_AS_EnInoutState;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                sent_en_d  = en_done;
                sent_cbm_d = cbm_done;
                if (en_done && cbm_done) begin
                    sent_en_d  = 1'b0;
                    sent_cbm_d = 1'b0;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (acc_xfer) begin
                    // Non-negative sum (sign bit clear, zero included) fires the neuron.
                    for (int i = 0; i < NH; i++) begin
                        hidden_d[i] = ~iData_AS_CbmAccum[i*CW+CW-1];
                    end
                    state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                if (st_xfer) begin
                    step_cnt_d = step_cnt_q + 16'd1;
                    // Compare the pre-increment count so 65535 steps never needs a 17th bit.
                    if (step_cnt_q == num_step_q - 16'd1) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q    <= S_IDLE;
            num_step_q <= '0;
            step_cnt_q <= '0;
            in_q       <= '0;
            hidden_q   <= '0;
            sent_en_q  <= 1'b0;
            sent_cbm_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            num_step_q <= num_step_d;
            step_cnt_q <= step_cnt_d;
            in_q       <= in_d;
            hidden_q   <= hidden_d;
            sent_en_q  <= sent_en_d;
            sent_cbm_q <= sent_cbm_d;
        end
    end

endmodule
